// File: rtl/uart_rx_oversampler.sv
// rtl/uart_rx_oversampler.sv - oversampling 8N1 UART receiver; even parity added when UART_RX_PARITY_EN is defined
module uart_rx_oversampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 8
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       RX,
    output logic       RX_DONE,
    output logic [7:0] RX_DATA,
    output logic       FRAME_ERR,
    output logic       PARITY_ERR,
    output logic       BUSY
);

    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shift, shift_n;
    logic [7:0]       data_q, data_n;
    logic             done_q, done_n;
    logic             ferr_q, ferr_n;
    logic             rx_meta, rx_s;
`ifdef UART_RX_PARITY_EN
    logic             par_bad, par_bad_n;
    logic             perr_q, perr_n;
`endif

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            ferr_q  <= 1'b0;
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            data_q  <= data_n;
            done_q  <= done_n;
            ferr_q  <= ferr_n;
            rx_meta <= RX;
            rx_s    <= rx_meta;
`ifdef UART_RX_PARITY_EN
            par_bad <= par_bad_n;
            perr_q  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        data_n    = data_q;
        done_n    = 1'b0;
        ferr_n    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = S_START;
            end
            // A start bit that is gone by its midpoint was a glitch.
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (cnt == BIT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = (^shift) ^ rx_s;
                    state_n   = S_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
`endif
            // Framing error outranks parity error.
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        ferr_n  = 1'b1;
                        state_n = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (par_bad) begin
                        perr_n  = 1'b1;
                        state_n = S_IDLE;
`endif
                    end else begin
                        data_n  = shift;
                        done_n  = 1'b1;
                        state_n = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign RX_DONE   = done_q;
    assign RX_DATA   = data_q;
    assign FRAME_ERR = ferr_q;
    assign BUSY      = (state != S_IDLE);
`ifdef UART_RX_PARITY_EN
    assign PARITY_ERR = perr_q;
`else
    assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// tb/tb_uart_rx_oversampler.sv - self-checking bench for uart_rx_oversampler (UART_RX_PARITY_EN aware)
module tb_uart_rx_oversampler;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    localparam int LAT = 2 + CPB / 2 + (FRAME_BITS - 1) * CPB + 1;
    localparam int EV_DONE = 0;
    localparam int EV_FERR = 1;
    localparam int EV_PERR = 2;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       RX = 1'b1;
    logic       RX_DONE, FRAME_ERR, PARITY_ERR, BUSY;
    logic [7:0] RX_DATA;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t        obs[$];
    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] last_good = 8'h00;

    uart_rx_oversampler #(.CLKS_PER_BIT(CPB), .CNT_W(8)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .RX(RX),
        .RX_DONE(RX_DONE),
        .RX_DATA(RX_DATA),
        .FRAME_ERR(FRAME_ERR),
        .PARITY_ERR(PARITY_ERR),
        .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        mon_e.data = 8'h00;
        mon_e.t    = cyc;
        if (RX_DONE)    begin mon_e.kind = EV_DONE; mon_e.data = RX_DATA; obs.push_back(mon_e); end
        if (FRAME_ERR)  begin mon_e.kind = EV_FERR; mon_e.data = 8'h00;   obs.push_back(mon_e); end
        if (PARITY_ERR) begin mon_e.kind = EV_PERR; mon_e.data = 8'h00;   obs.push_back(mon_e); end
    end

    function automatic ev_t obs_at(input int i);
        ev_t e;
        e.kind = -1; e.data = 8'h00; e.t = 0;
        if (i < obs.size()) e = obs[i];
        return e;
    endfunction

    task automatic hold(input logic v, input int n);
        RX = v;
        repeat (n) begin @(posedge CLK); #1; end
    endtask

    // Model: stop=0 gives a framing error; bad parity (parity build only) a parity error; else a good byte.
    task automatic send(input logic [7:0] d, input logic stop_b, input logic par_flip);
        ev_t e;
        logic par_bad;
`ifdef UART_RX_PARITY_EN
        par_bad = par_flip;
`else
        par_bad = 1'b0;
`endif
        e.data = 8'h00; e.t = 0;
        if (!stop_b)      e.kind = EV_FERR;
        else if (par_bad) e.kind = EV_PERR;
        else begin e.kind = EV_DONE; e.data = d; last_good = d; end
        exp_q.push_back(e);
        hold(1'b0, CPB);
        for (int i = 0; i < 8; i++) hold(d[i], CPB);
`ifdef UART_RX_PARITY_EN
        hold((^d) ^ par_flip, CPB);
`endif
        hold(stop_b, CPB);
    endtask

    task automatic test_reset;
        RESET = 1'b1; RX = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        vectors++; if (RX_DONE !== 1'b0)    begin miscompares++; $display("FAIL reset_rx_done: got %b want 0", RX_DONE); end
        vectors++; if (FRAME_ERR !== 1'b0)  begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", FRAME_ERR); end
        vectors++; if (PARITY_ERR !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err: got %b want 0", PARITY_ERR); end
        vectors++; if (BUSY !== 1'b0)       begin miscompares++; $display("FAIL reset_busy: got %b want 0", BUSY); end
        vectors++; if (RX_DATA !== 8'h00)   begin miscompares++; $display("FAIL reset_rx_data: got %02h want 00", RX_DATA); end
        RESET = 1'b0;
        obs.delete(); exp_q.delete(); last_good = 8'h00;
        hold(1'b1, 100);
        vectors++; if (obs.size() != 0)     begin miscompares++; $display("FAIL idle_events: got %0d want 0", obs.size()); end
        vectors++; if (BUSY !== 1'b0)       begin miscompares++; $display("FAIL idle_busy: got %b want 0", BUSY); end
        vectors++; if (RX_DATA !== 8'h00)   begin miscompares++; $display("FAIL idle_rx_data: got %02h want 00", RX_DATA); end
    endtask

    task automatic test_single;
        int t0, lat;
        obs.delete(); exp_q.delete();
        t0 = cyc;
        send(8'hA5, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        lat = obs_at(0).t - t0;
        vectors++; if (obs.size() != 1)            begin miscompares++; $display("FAIL single_count: got %0d want 1", obs.size()); end
        vectors++; if (obs_at(0).kind != EV_DONE)  begin miscompares++; $display("FAIL single_kind: got %0d want %0d", obs_at(0).kind, EV_DONE); end
        vectors++; if (RX_DATA !== 8'hA5)          begin miscompares++; $display("FAIL single_data: got %02h want a5", RX_DATA); end
        vectors++; if (lat < LAT - 1 || lat > LAT + 1) begin miscompares++; $display("FAIL single_latency: got %0d want %0d+-1", lat, LAT); end
        vectors++; if (BUSY !== 1'b0)              begin miscompares++; $display("FAIL single_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_glitch;
        obs.delete();
        hold(1'b0, 5);
        vectors++; if (BUSY !== 1'b1)   begin miscompares++; $display("FAIL glitch_busy_start: got %b want 1", BUSY); end
        hold(1'b1, 3 * CPB);
        vectors++; if (BUSY !== 1'b0)   begin miscompares++; $display("FAIL glitch_busy_end: got %b want 0", BUSY); end
        vectors++; if (obs.size() != 0) begin miscompares++; $display("FAIL glitch_events: got %0d want 0", obs.size()); end
    endtask

    task automatic test_frame_error;
        obs.delete(); exp_q.delete();
        send(8'hA5, 1'b1, 1'b0);
        send(8'h3C, 1'b0, 1'b0);
        hold(1'b0, 40);
        vectors++; if (BUSY !== 1'b1) begin miscompares++; $display("FAIL ferr_break_busy: got %b want 1", BUSY); end
        hold(1'b1, 2 * CPB);
        vectors++; if (BUSY !== 1'b0) begin miscompares++; $display("FAIL ferr_idle_busy: got %b want 0", BUSY); end
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL ferr_count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (obs_at(i).kind != exp_q[i].kind || obs_at(i).data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL ferr_event%0d: got kind %0d data %02h want kind %0d data %02h", i, obs_at(i).kind, obs_at(i).data, exp_q[i].kind, exp_q[i].data);
            end
        end
        vectors++; if (RX_DATA !== 8'hA5) begin miscompares++; $display("FAIL ferr_data_held: got %02h want a5", RX_DATA); end
    endtask

    task automatic test_back_to_back;
        obs.delete(); exp_q.delete();
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        vectors++; if (obs.size() != 2) begin miscompares++; $display("FAIL b2b_count: got %0d want 2", obs.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (obs_at(i).kind != exp_q[i].kind || obs_at(i).data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL b2b_event%0d: got kind %0d data %02h want kind %0d data %02h", i, obs_at(i).kind, obs_at(i).data, exp_q[i].kind, exp_q[i].data);
            end
        end
        vectors++;
        if (obs_at(1).t - obs_at(0).t != FRAME_BITS * CPB) begin
            miscompares++; $display("FAIL b2b_spacing: got %0d want %0d", obs_at(1).t - obs_at(0).t, FRAME_BITS * CPB);
        end
        vectors++; if (RX_DATA !== 8'hFF) begin miscompares++; $display("FAIL b2b_data: got %02h want ff", RX_DATA); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] d;
        d = 8'h5A;
        obs.delete(); exp_q.delete();
        hold(1'b0, CPB);
        for (int i = 0; i < 4; i++) hold(d[i], CPB);
        hold(d[4], CPB / 2);
        RESET = 1'b1; RX = 1'b1;
        @(posedge CLK); #1;
        RESET = 1'b0;
        last_good = 8'h00;
        vectors++; if (BUSY !== 1'b0)     begin miscompares++; $display("FAIL midreset_busy: got %b want 0", BUSY); end
        vectors++; if (RX_DATA !== 8'h00) begin miscompares++; $display("FAIL midreset_data: got %02h want 00", RX_DATA); end
        hold(1'b1, 2 * CPB);
        send(8'h81, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        vectors++; if (obs.size() != 1)           begin miscompares++; $display("FAIL midreset_count: got %0d want 1", obs.size()); end
        vectors++; if (obs_at(0).kind != EV_DONE || obs_at(0).data !== 8'h81) begin
            miscompares++; $display("FAIL midreset_event: got kind %0d data %02h want kind 0 data 81", obs_at(0).kind, obs_at(0).data);
        end
        vectors++; if (RX_DATA !== 8'h81) begin miscompares++; $display("FAIL midreset_rx_data: got %02h want 81", RX_DATA); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        obs.delete(); exp_q.delete();
        send(8'h07, 1'b1, 1'b0);
        hold(1'b1, 2 * CPB);
        send(8'h07, 1'b1, 1'b1);
        hold(1'b1, 2 * CPB);
        vectors++; if (obs.size() != 2) begin miscompares++; $display("FAIL parity_count: got %0d want 2", obs.size()); end
        vectors++; if (obs_at(0).kind != EV_DONE || obs_at(0).data !== 8'h07) begin
            miscompares++; $display("FAIL parity_good: got kind %0d data %02h want kind 0 data 07", obs_at(0).kind, obs_at(0).data);
        end
        vectors++; if (obs_at(1).kind != EV_PERR) begin miscompares++; $display("FAIL parity_bad: got kind %0d want %0d", obs_at(1).kind, EV_PERR); end
        vectors++; if (RX_DATA !== 8'h07) begin miscompares++; $display("FAIL parity_data: got %02h want 07", RX_DATA); end
    endtask
`endif

    task automatic test_random;
        logic [7:0] d;
        logic       stop_b, par_flip;
        obs.delete(); exp_q.delete();
        for (int n = 0; n < 40; n++) begin
            d        = 8'($urandom);
            stop_b   = ($urandom_range(0, 5) != 0);
            par_flip = ($urandom_range(0, 3) == 0);
            send(d, stop_b, par_flip);
            if (!stop_b) hold(1'b1, CPB + $urandom_range(0, 8));
            else         hold(1'b1, $urandom_range(0, 3));
        end
        hold(1'b1, 2 * CPB);
        vectors++; if (obs.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_count: got %0d want %0d", obs.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            vectors++;
            if (obs_at(i).kind != exp_q[i].kind || obs_at(i).data !== exp_q[i].data) begin
                miscompares++;
                $display("FAIL rand_event%0d: got kind %0d data %02h want kind %0d data %02h", i, obs_at(i).kind, obs_at(i).data, exp_q[i].kind, exp_q[i].data);
            end
        end
        vectors++; if (RX_DATA !== last_good) begin miscompares++; $display("FAIL rand_data: got %02h want %02h", RX_DATA, last_good); end
        vectors++; if (BUSY !== 1'b0)         begin miscompares++; $display("FAIL rand_busy: got %b want 0", BUSY); end
    endtask

    initial begin
        test_reset;
        test_single;
        test_glitch;
        test_frame_error;
        test_back_to_back;
        test_reset_mid_frame;
`ifdef UART_RX_PARITY_EN
        test_parity;
`endif
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
